// File: rtl/exe_stage.sv
// exe_stage: EXE pipeline stage of the in-order CPU. It computes the ALU
// result and checks load/store alignment. It drives the data SRAM request
// handshake and filters data_ok responses that belong to flushed
// instructions, so MEM only sees responses for live loads and stores.
// Optional feature: define ES_FORWARD_EN to forward the ALU result to ID.
// When it is not defined, forward_es_bus is tied to zero.
//
// ds_to_es_bus (MSB..LSB): pc[32] exc[8] alu_op[3] load store size[2] uns
//                          res_from_cp0 gr_we[4] dest[5] src1[32] src2[32]
//                          st_data[32]
// es_to_ms_bus (MSB..LSB): pc[32] exc[8] badvaddr[32] res_from_mem store_op
//                          size[2] uns addr_lo[2] res_from_cp0 gr_we[4]
//                          dest[5] alu_result[32]
// Exception vector bit 4 = ADEL, bit 5 = ADES.

module exe_alu (
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  // Op codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 lui
  always_comb begin
    case (op_i)
      3'd0:    y_o = a_i + b_i;
      3'd1:    y_o = a_i - b_i;
      3'd2:    y_o = a_i & b_i;
      3'd3:    y_o = a_i | b_i;
      3'd4:    y_o = a_i ^ b_i;
      3'd5:    y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      3'd6:    y_o = {31'b0, a_i < b_i};
      default: y_o = {b_i[15:0], 16'h0000};
    endcase
  end
endmodule

module exe_stage #(
  parameter  int CNCL_W          = 2,
  localparam int DS_TO_ES_BUS_WD = 154,
  localparam int ES_TO_MS_BUS_WD = 121,
  localparam int FORWARD_BUS_WD  = 33
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [1:0]                 ms_exc_eret_bus,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [1:0]                 data_sram_size,
  output logic [3:0]                 data_sram_wstrb,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  output logic                       ms_data_ok,
  output logic [FORWARD_BUS_WD-1:0]  forward_es_bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, CNCL} state_e;

  localparam logic [CNCL_W-1:0] CNT_MAX = '1;

  logic                       es_valid_q;
  logic [DS_TO_ES_BUS_WD-1:0] payload_q;
  state_e                     state_q, state_d;
  logic [CNCL_W-1:0]          cnt_q, cnt_d;

  logic [31:0] es_pc, es_src1, es_src2, es_st_data, alu_result;
  logic [7:0]  es_exc_in, exc_vec;
  logic [2:0]  es_alu_op;
  logic [1:0]  es_size;
  logic [3:0]  es_gr_we;
  logic [4:0]  es_dest;
  logic        es_load, es_store, es_uns, es_from_cp0;
  logic        misalign, adel, ades, es_exc, mem_op, cnt_sat;
  logic        req, hs, es_ready_go, inc, dec;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  assign {es_pc, es_exc_in, es_alu_op, es_load, es_store, es_size, es_uns,
          es_from_cp0, es_gr_we, es_dest, es_src1, es_src2, es_st_data} = payload_q;

  exe_alu u_alu (
    .op_i (es_alu_op),
    .a_i  (es_src1),
    .b_i  (es_src2),
    .y_o  (alu_result)
  );

  assign misalign = ((es_size == 2'd2) && (alu_result[1:0] != 2'b00)) ||
                    ((es_size == 2'd1) && alu_result[0]);
  assign adel     = es_load && misalign;
  assign ades     = es_store && misalign;
  assign exc_vec  = es_exc_in | {2'b00, ades, adel, 4'b0000};
  assign es_exc   = |exc_vec;

  // A memory access is only started for a live, exception-free instruction
  // with nothing older in MEM about to redirect the pipeline.
  assign mem_op  = es_valid_q && (es_load || es_store) && !es_exc &&
                   !ms_exc_eret_bus[1] && !ms_exc_eret_bus[0] && !flush;
  assign cnt_sat = (cnt_q == CNT_MAX);

  // Request is raised straight from IDLE and held through REQ/CNCL until accepted
  always_comb begin
    req = 1'b0;
    case (state_q)
      IDLE:      req = mem_op && !cnt_sat;
      REQ, CNCL: req = 1'b1;
      default:   req = 1'b0;
    endcase
  end

  assign hs = req && data_sram_addr_ok;

  // The instruction may leave once its request is accepted (or it needs none)
  always_comb begin
    es_ready_go = 1'b0;
    case (state_q)
      IDLE:    es_ready_go = !mem_op || hs;
      REQ:     es_ready_go = hs;
      DONE:    es_ready_go = 1'b1;
      default: es_ready_go = 1'b0;
    endcase
  end

  assign es_allowin     = (state_q != CNCL) && (!es_valid_q || (es_ready_go && ms_allowin));
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  // Handshake state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs)       state_d = ms_allowin ? IDLE : DONE;
        else if (req) state_d = REQ;
      end
      REQ: begin
        if (hs)         state_d = (flush || ms_allowin) ? IDLE : DONE;
        else if (flush) state_d = CNCL;
      end
      DONE:    if (ms_allowin || flush) state_d = IDLE;
      CNCL:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count accepted requests whose instruction was flushed; their data_ok is swallowed
  always_comb begin
    inc   = hs && ((state_q == CNCL) || ((state_q == REQ) && flush));
    dec   = data_sram_data_ok && (cnt_q != '0);
    cnt_d = cnt_q;
    if (inc && !dec && !cnt_sat) cnt_d = cnt_q + 1'b1;
    else if (dec && !inc)        cnt_d = cnt_q - 1'b1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
    end else begin
      if (flush)           es_valid_q <= 1'b0;
      else if (es_allowin) es_valid_q <= ds_to_es_valid;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction payload; no reset needed because es_valid_q qualifies it
  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) payload_q <= ds_to_es_bus;
  end

  // Byte-lane strobes and replicated store data; loads write no lanes
  always_comb begin
    wstrb = 4'b0000;
    wdata = es_st_data;
    if (es_store) begin
      case (es_size)
        2'd0: begin
          wstrb = 4'b0001 << alu_result[1:0];
          wdata = {4{es_st_data[7:0]}};
        end
        2'd1: begin
          wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
          wdata = {2{es_st_data[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  assign data_sram_req   = req;
  assign data_sram_wr    = es_store;
  assign data_sram_size  = es_size;
  assign data_sram_wstrb = wstrb;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = wdata;
  assign ms_data_ok      = data_sram_data_ok && (cnt_q == '0);

  // An excepting instruction must not make MEM wait for a data_ok that never comes
  assign es_to_ms_bus = {es_pc, exc_vec, alu_result,
                         es_load && !es_exc, es_store && !es_exc,
                         es_size, es_uns, alu_result[1:0], es_from_cp0,
                         es_gr_we, es_dest, alu_result};

`ifdef ES_FORWARD_EN
  assign forward_es_bus = {es_valid_q && !es_load && !es_from_cp0 && (es_gr_we != 4'h0),
                           alu_result};
`else
  assign forward_es_bus = '0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of single instructions plus
// hand-written handshake, cancel, saturation and reset sequences.
module tb_exe_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, flush, ms_allowin, es_allowin, ds_to_es_valid;
  logic [153:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [120:0] es_to_ms_bus;
  logic [1:0]   ms_exc_eret_bus;
  logic         data_sram_req, data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         data_sram_addr_ok, data_sram_data_ok, ms_data_ok;
  logic [32:0]  forward_es_bus;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_exc_eret_bus   (ms_exc_eret_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .ms_data_ok        (ms_data_ok),
    .forward_es_bus    (forward_es_bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        req;
    logic [31:0] alu;
    logic [7:0]  exc;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [153:0] mk(input logic [2:0] op, input logic ld, input logic st,
                                      input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] d);
    return {32'hBFC0_0000, 8'h00, op, ld, st, sz, 1'b0, 1'b0, 4'hF, 5'd8, a, b, d};
  endfunction

  task automatic load(input logic [153:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    tick();
    ds_to_es_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] fwd_exp;
    //           op    ld    st    sz    a             b           d              req   alu            exc    wstrb  wdata
    tbl[0]  = '{3'd0, 1'b0, 1'b0, 2'd0, 32'd5,        32'd7,      32'd0,         1'b0, 32'd12,        8'h00, 4'h0, 32'h0};
    tbl[1]  = '{3'd1, 1'b0, 1'b0, 2'd0, 32'd3,        32'd5,      32'd0,         1'b0, 32'hFFFFFFFE,  8'h00, 4'h0, 32'h0};
    tbl[2]  = '{3'd5, 1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd1,      32'd0,         1'b0, 32'd1,         8'h00, 4'h0, 32'h0};
    tbl[3]  = '{3'd6, 1'b0, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd1,      32'd0,         1'b0, 32'd0,         8'h00, 4'h0, 32'h0};
    tbl[4]  = '{3'd7, 1'b0, 1'b0, 2'd0, 32'd0,        32'h1234,   32'd0,         1'b0, 32'h12340000,  8'h00, 4'h0, 32'h0};
    tbl[5]  = '{3'd4, 1'b0, 1'b0, 2'd0, 32'hF0F0,     32'hFF00,   32'd0,         1'b0, 32'h0FF0,      8'h00, 4'h0, 32'h0};
    tbl[6]  = '{3'd2, 1'b0, 1'b0, 2'd0, 32'hF0F0,     32'hFF00,   32'd0,         1'b0, 32'hF000,      8'h00, 4'h0, 32'h0};
    tbl[7]  = '{3'd3, 1'b0, 1'b0, 2'd0, 32'h0F,       32'hF0,     32'd0,         1'b0, 32'hFF,        8'h00, 4'h0, 32'h0};
    tbl[8]  = '{3'd0, 1'b1, 1'b0, 2'd2, 32'hFC,       32'd4,      32'd0,         1'b1, 32'h100,       8'h00, 4'h0, 32'h0};
    tbl[9]  = '{3'd0, 1'b0, 1'b1, 2'd0, 32'h100,      32'd3,      32'hAB,        1'b1, 32'h103,       8'h00, 4'h8, 32'hABABABAB};
    tbl[10] = '{3'd0, 1'b0, 1'b1, 2'd1, 32'h100,      32'd2,      32'h1234CDEF,  1'b1, 32'h102,       8'h00, 4'hC, 32'hCDEFCDEF};
    tbl[11] = '{3'd0, 1'b0, 1'b1, 2'd2, 32'h100,      32'd2,      32'd1,         1'b0, 32'h102,       8'h20, 4'h0, 32'h0};
    tbl[12] = '{3'd0, 1'b1, 1'b0, 2'd1, 32'h100,      32'd1,      32'd0,         1'b0, 32'h101,       8'h10, 4'h0, 32'h0};
    tbl[13] = '{3'd0, 1'b0, 1'b1, 2'd0, 32'h100,      32'd1,      32'h5A,        1'b1, 32'h101,       8'h00, 4'h2, 32'h5A5A5A5A};
    tbl[14] = '{3'd0, 1'b0, 1'b1, 2'd2, 32'h1F0,      32'h10,     32'hDEADBEEF,  1'b1, 32'h200,       8'h00, 4'hF, 32'hDEADBEEF};
    tbl[15] = '{3'd0, 1'b1, 1'b0, 2'd1, 32'h100,      32'd2,      32'd0,         1'b1, 32'h102,       8'h00, 4'h0, 32'h0};

    resetn = 1'b0; flush = 1'b0; ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0; ms_exc_eret_bus = 2'b00;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;

    // reset state
    #3;
    chk("rst_req", data_sram_req, 1'b0);
    chk("rst_vld", es_to_ms_valid, 1'b0);
    chk("rst_msdok", ms_data_ok, 1'b0);
    chk("rst_allowin", es_allowin, 1'b1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // table of single instructions, MEM always ready
    for (int i = 0; i < 16; i++) begin
      load(mk(tbl[i].op, tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].a, tbl[i].b, tbl[i].d));
      #1;
      chk($sformatf("v%0d_req", i), data_sram_req, tbl[i].req);
      chk($sformatf("v%0d_alu", i), es_to_ms_bus[31:0], tbl[i].alu);
      chk($sformatf("v%0d_exc", i), es_to_ms_bus[88:81], tbl[i].exc);
      chk($sformatf("v%0d_vld", i), es_to_ms_valid, !tbl[i].req);
      if (i == 0) begin
`ifdef ES_FORWARD_EN
        fwd_exp = {1'b1, 32'd12};
`else
        fwd_exp = '0;
`endif
        chk("v0_fwd", forward_es_bus, fwd_exp);
      end
      if (tbl[i].req) begin
        chk($sformatf("v%0d_wr", i), data_sram_wr, tbl[i].st);
        chk($sformatf("v%0d_size", i), data_sram_size, tbl[i].sz);
        chk($sformatf("v%0d_addr", i), data_sram_addr, tbl[i].alu);
        chk($sformatf("v%0d_wstrb", i), data_sram_wstrb, tbl[i].wstrb);
        if (tbl[i].st) chk($sformatf("v%0d_wdata", i), data_sram_wdata, tbl[i].wdata);
        data_sram_addr_ok = 1'b1;
        #1 chk($sformatf("v%0d_vld_ok", i), es_to_ms_valid, 1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
      end else begin
        if (tbl[i].exc != 8'h00) begin
          chk($sformatf("v%0d_badv", i), es_to_ms_bus[80:49], tbl[i].alu);
          chk($sformatf("v%0d_stop", i), es_to_ms_bus[47], 1'b0);
          chk($sformatf("v%0d_rfm", i), es_to_ms_bus[48], 1'b0);
        end
        tick();
      end
    end

    // lw with addr_ok on its second cycle
    load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
    #1;
    chk("lw_req_c1", data_sram_req, 1'b1);
    chk("lw_vld_c1", es_to_ms_valid, 1'b0);
    tick();
    data_sram_addr_ok = 1'b1;
    #1;
    chk("lw_req_c2", data_sram_req, 1'b1);
    chk("lw_vld_c2", es_to_ms_valid, 1'b1);
    chk("lw_addr_c2", data_sram_addr, 32'h100);
    tick();
    data_sram_addr_ok = 1'b0;
    #1;
    chk("lw_req_c3", data_sram_req, 1'b0);
    chk("lw_vld_c3", es_to_ms_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    #1 chk("lw_msdok", ms_data_ok, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // flush while the request is outstanding: request held, response swallowed
    load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
    #1 chk("cn_req_c1", data_sram_req, 1'b1);
    tick();
    flush = 1'b1;
    #1 chk("cn_req_c2", data_sram_req, 1'b1);
    tick();
    flush = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(3'd0, 1'b0, 1'b0, 2'd0, 32'h40, 32'h4, 32'd0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("cn_req_w%0d", c), data_sram_req, 1'b1);
      chk($sformatf("cn_addr_w%0d", c), data_sram_addr, 32'h100);
      chk($sformatf("cn_wr_w%0d", c), data_sram_wr, 1'b0);
      chk($sformatf("cn_allowin_w%0d", c), es_allowin, 1'b0);
      chk($sformatf("cn_vld_w%0d", c), es_to_ms_valid, 1'b0);
      tick();
    end
    ds_to_es_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    #1;
    chk("cn_req_ok", data_sram_req, 1'b1);
    chk("cn_addr_ok", data_sram_addr, 32'h100);
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    #1;
    chk("cn_msdok_supp", ms_data_ok, 1'b0);
    chk("cn_req_after", data_sram_req, 1'b0);
    tick();
    chk("cn_msdok_pass", ms_data_ok, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // accepted while MEM is stalled: wait in DONE without re-requesting
    ms_allowin = 1'b0;
    load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
    data_sram_addr_ok = 1'b1;
    #1;
    chk("dn_req_c1", data_sram_req, 1'b1);
    chk("dn_vld_c1", es_to_ms_valid, 1'b1);
    chk("dn_allowin_c1", es_allowin, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("dn_req_w%0d", c), data_sram_req, 1'b0);
      chk($sformatf("dn_vld_w%0d", c), es_to_ms_valid, 1'b1);
      chk($sformatf("dn_allowin_w%0d", c), es_allowin, 1'b0);
    end
    ms_allowin = 1'b1;
    data_sram_addr_ok = 1'b0;
    #1 chk("dn_allowin_go", es_allowin, 1'b1);
    tick();
    chk("dn_vld_gone", es_to_ms_valid, 1'b0);
    chk("dn_req_gone", data_sram_req, 1'b0);

    // older instruction in MEM has exc/eret: store must not issue
    ms_allowin = 1'b0;
    ms_exc_eret_bus = 2'b10;
    load(mk(3'd0, 1'b0, 1'b1, 2'd2, 32'h1F0, 32'h10, 32'h1));
    #1;
    chk("ex_req_exc", data_sram_req, 1'b0);
    chk("ex_vld_exc", es_to_ms_valid, 1'b1);
    tick();
    chk("ex_req_exc2", data_sram_req, 1'b0);
    ms_exc_eret_bus = 2'b01;
    #1 chk("ex_req_eret", data_sram_req, 1'b0);
    ms_exc_eret_bus = 2'b00;
    #1 chk("ex_req_clear", data_sram_req, 1'b1);
    data_sram_addr_ok = 1'b1;
    ms_allowin = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    chk("ex_vld_gone", es_to_ms_valid, 1'b0);

    // three cancelled requests saturate the counter and block new requests
    for (int k = 0; k < 3; k++) begin
      load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      data_sram_addr_ok = 1'b1;
      tick();
      data_sram_addr_ok = 1'b0;
    end
    load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
    #1;
    chk("sat_req", data_sram_req, 1'b0);
    chk("sat_vld", es_to_ms_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    #1 chk("sat_msdok", ms_data_ok, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    #1 chk("sat_req_unblk", data_sram_req, 1'b1);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 chk($sformatf("sat_msdok_supp%0d", c), ms_data_ok, 1'b0);
      tick();
    end
    #1 chk("sat_msdok_live", ms_data_ok, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // asynchronous reset in the middle of a handshake
    load(mk(3'd0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'd4, 32'd0));
    tick();
    #1 chk("ar_req_before", data_sram_req, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("ar_req", data_sram_req, 1'b0);
    chk("ar_vld", es_to_ms_valid, 1'b0);
    chk("ar_allowin", es_allowin, 1'b1);
    tick();
    resetn = 1'b1;
    tick();
    chk("ar_req_post", data_sram_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter: CNCL_W, default 2, width of the cancelled-request counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  pipeline flush (exception/eret taken in WB).
REQ-005 ms_allowin  in  1  MEM stage can accept.
REQ-006 es_allowin  out  1  EXE stage can accept.
REQ-007 ds_to_es_valid  in  1; ds_to_es_bus  in  DS_TO_ES_BUS_WD  decoded instruction from ID.
REQ-008 es_to_ms_valid  out  1; es_to_ms_bus  out  ES_TO_MS_BUS_WD  MEM-stage payload, field order fixed by mycpu.h.
REQ-009 ms_exc_eret_bus  in  2  {ms_exc, ms_eret} of the instruction in MEM.
REQ-010 data_sram_req  out  1; data_sram_wr  out  1; data_sram_size  out  2; data_sram_wstrb  out  4; data_sram_addr  out  32; data_sram_wdata  out  32.
REQ-011 data_sram_addr_ok  in  1; data_sram_data_ok  in  1.
REQ-012 ms_data_ok  out  1  filtered data_ok, consumed by MEM in place of raw data_ok.
REQ-013 forward_es_bus  out  FORWARD_BUS_WD  {fwd_valid, alu_result}.

Function
REQ-014 Payload register loads ds_to_es_bus when ds_to_es_valid && es_allowin; es_valid loads ds_to_es_valid when es_allowin; flush clears es_valid.
REQ-015 es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
REQ-016 ALU result comes from the existing alu instance; mem address = alu_result.
REQ-017 Alignment: lw/sw with addr[1:0]!=0, lh/lhu/sh with addr[0]!=0 raise ADEL (load) or ADES (store); type ORed into the exception vector, badvaddr = addr.
REQ-018 mem_op = es_valid && (load || store) && !es_exc && !ms_exc_eret_bus[1] && !ms_exc_eret_bus[0] && !flush.
REQ-019 When es_exc is set, the forwarded res_from_mem and store_op bits are cleared so MEM never waits for data_ok.
REQ-020 FSM states IDLE, REQ, DONE, CNCL; reset state IDLE.
REQ-021 IDLE: mem_op -> REQ (req asserted the same cycle, combinationally from IDLE when mem_op).
REQ-022 REQ (or IDLE with mem_op): addr_ok -> DONE if !ms_allowin, else IDLE (instruction leaves); flush without addr_ok -> CNCL.
REQ-023 DONE: req low; es_ready_go=1; ms_allowin -> IDLE; flush -> IDLE with cnt+1 not applied (handshake already counted, see REQ-026).
REQ-024 CNCL: req held high with unchanged addr/wr/size/wstrb/wdata until addr_ok, then IDLE; es_allowin=0 while in CNCL.
REQ-025 es_ready_go = !mem_op_pending || addr_ok || state==DONE; non-memory instructions ready in one cycle.
REQ-026 Cancel counter cnt (CNCL_W bits): +1 on any accepted request (req&&addr_ok) whose instruction is flushed before or at its leaving edge; -1 on data_ok while cnt!=0; simultaneous +1/-1 leaves cnt unchanged; cnt saturates at 2^CNCL_W-1 and blocks new requests while saturated.
REQ-027 ms_data_ok = data_sram_data_ok && (cnt==0).
REQ-028 Stores: size from op (0 byte, 1 half, 2 word); wstrb and wdata replicated per addr[1:0] (sb 0001<<a, sh 0011/1100, sw 1111); loads drive wstrb=0.
REQ-029 Request fields stable while req high and !addr_ok.

Reset
REQ-030 On resetn low, immediately: es_valid=0, FSM=IDLE, cnt=0, data_sram_req=0, es_to_ms_valid=0, ms_data_ok=0; payload register undefined but unobservable.
REQ-031 Reset mid-handshake abandons the request; the memory side is reset by the same resetn.

Configuration
REQ-032 Macro ES_FORWARD_EN: defined -> fwd_valid = es_valid && !res_from_mem && !res_from_cp0 && gr_we!=0, data = alu_result; undefined -> forward_es_bus tied to 0 and ID stalls on any EXE dependency.

Verification
REQ-033 lw addr 0x100, addr_ok on cycle 2, ms_allowin=1 -> req high cycles 1-2, es_to_ms_valid in cycle 2, FSM back to IDLE.
REQ-034 sb to 0x103 data 0xAB -> wstrb=1000, wdata=0xABABABAB, size=0, wr=1.
REQ-035 sw to 0x102 -> no req, ADES set, badvaddr=0x102, store_op cleared in bus.
REQ-036 lw, flush while REQ, addr_ok 3 cycles later -> req held stable, cnt goes 1, next data_ok suppressed on ms_data_ok, cnt returns 0.
REQ-037 addr_ok with ms_allowin=0 for 4 cycles -> DONE, req low, single request issued, leaves when ms_allowin rises.
REQ-038 sw in EXE while ms_exc_eret_bus=2'b10 -> req never asserted.
